// File: rtl/output_conditioner.sv
// Output conditioner: turns 1-clk set/clear request pulses into a registered
// level that never changes more often than once every HOLD cycles.
// Requests arriving inside a hold window are buffered (depth 1, last wins)
// and applied at the first edge where a change is allowed again.
module output_conditioner #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned W    = 3,
    parameter logic        INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    output logic sig_out,
    output logic rising,
    output logic falling,
    output logic busy,
    output logic pend,
    output logic conflict
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_RELOAD = W'(HOLD - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   w_cnt_nxt;
    logic           r_sig;
    logic           w_sig_nxt;
    logic           r_pend;
    logic           w_pend_nxt;
    logic           r_rising;
    logic           r_falling;
    logic           r_conflict;
    logic           w_flip;
    logic           w_req_valid;
    logic           w_conflict;
    logic           w_new_eff;
    logic           w_cand_eff;
    logic           w_cnt_zero;

    // A simultaneous set and clear is treated as no request at all; a lone
    // request only matters when it asks for the opposite of the current level.
    // The buffer only ever holds a request that differs from the current
    // level, so a single valid flag is enough to describe it.
    assign w_conflict  = set_req & clr_req;
    assign w_req_valid = set_req ^ clr_req;
    assign w_new_eff   = w_req_valid & (set_req != r_sig);
    assign w_cand_eff  = w_req_valid ? w_new_eff : r_pend;
    assign w_cnt_zero  = (r_cnt == '0);

    // State register plus every registered output, so no input reaches a pin
    // without passing through a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sig      <= INIT;
            r_pend     <= 1'b0;
            r_rising   <= 1'b0;
            r_falling  <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sig      <= w_sig_nxt;
            r_pend     <= w_pend_nxt;
            r_rising   <= w_flip & ~r_sig;
            r_falling  <= w_flip & r_sig;
            r_conflict <= w_conflict;
        end
    end

    // Next-state decision: leave HOLD only when the window expires with
    // nothing worth applying.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_new_eff) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero && !w_cand_eff) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath updates: level flips, hold counter reloads and the pending
    // buffer, which a newer request always overwrites.
    always_comb begin
        w_flip     = 1'b0;
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = r_pend;
        case (r_state)
            ST_IDLE: begin
                w_pend_nxt = 1'b0;
                if (w_new_eff) begin
                    w_flip    = 1'b1;
                    w_cnt_nxt = CNT_RELOAD;
                end
            end
            ST_HOLD: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - W'(1);
                    if (w_req_valid) begin
                        w_pend_nxt = w_new_eff;
                    end
                end else begin
                    w_pend_nxt = 1'b0;
                    if (w_cand_eff) begin
                        w_flip    = 1'b1;
                        w_cnt_nxt = CNT_RELOAD;
                    end
                end
            end
            default: begin
                w_cnt_nxt  = '0;
                w_pend_nxt = 1'b0;
            end
        endcase
        w_sig_nxt = r_sig ^ w_flip;
    end

    assign sig_out  = r_sig;
    assign rising   = r_rising;
    assign falling  = r_falling;
    assign busy     = (r_state == ST_HOLD);
    assign pend     = r_pend;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_output_conditioner.sv
// Testbench for output_conditioner: two instances (HOLD=4 with INIT=0 and
// HOLD=1 with INIT=1) share the same request stream. A time-based model
// (last flip edge, pending flag) predicts every output and is compared on
// each falling clock edge; directed sequences add literal expectations.
module tb_output_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic setReq = 1'b0;
    logic clrReq = 1'b0;

    logic sig4, rise4, fall4, busy4, pend4, conf4;
    logic sig1, rise1, fall1, busy1, pend1, conf1;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;

    // Model state, index 0 = HOLD 4 instance, index 1 = HOLD 1 instance.
    int     holdLen [2] = '{4, 1};
    logic   initVal [2] = '{1'b0, 1'b1};
    logic   mSig    [2];
    logic   mPend   [2];
    logic   mRise   [2];
    logic   mFall   [2];
    logic   mBusy   [2];
    logic   mConf   [2];
    longint mLast   [2];
    longint edgeNo = 0;

    output_conditioner #(.HOLD(4), .W(3), .INIT(1'b0)) dut4 (
        .clk(clk), .reset(reset), .set_req(setReq), .clr_req(clrReq),
        .sig_out(sig4), .rising(rise4), .falling(fall4),
        .busy(busy4), .pend(pend4), .conflict(conf4)
    );

    output_conditioner #(.HOLD(1), .W(1), .INIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .set_req(setReq), .clr_req(clrReq),
        .sig_out(sig1), .rising(rise1), .falling(fall1),
        .busy(busy1), .pend(pend1), .conflict(conf1)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edgeNo, act, exp);
        end
    endtask

    // Behavioural model: a level may only change HOLD edges after its last
    // change; requests seen before then are remembered (last one wins) and
    // the edge exactly HOLD after the flip decides using new-or-pending.
    task automatic modelStep(input logic r, input logic s, input logic c);
        logic reqValid;
        logic eff;
        reqValid = s ^ c;
        for (int i = 0; i < 2; i++) begin
            mRise[i] = 1'b0;
            mFall[i] = 1'b0;
            if (r) begin
                mSig[i]  = initVal[i];
                mPend[i] = 1'b0;
                mConf[i] = 1'b0;
                mLast[i] = -1000;
            end else begin
                mConf[i] = s & c;
                if ((edgeNo - mLast[i]) < longint'(holdLen[i])) begin
                    if (reqValid) mPend[i] = (s != mSig[i]);
                end else begin
                    eff = reqValid ? (s != mSig[i]) : mPend[i];
                    mPend[i] = 1'b0;
                    if (eff) begin
                        mSig[i]  = ~mSig[i];
                        mRise[i] = mSig[i];
                        mFall[i] = ~mSig[i];
                        mLast[i] = edgeNo;
                    end
                end
            end
            mBusy[i] = (edgeNo - mLast[i]) < longint'(holdLen[i]);
        end
        edgeNo++;
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model, then
    // return 1 time unit after the edge so callers sample settled outputs.
    task automatic applyStimulus(input logic r, input logic s, input logic c);
        reset  = r;
        setReq = s;
        clrReq = c;
        @(posedge clk);
        modelStep(r, s, c);
        #1;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("sig4",  sig4,  mSig[0]);
            checkOutput("rise4", rise4, mRise[0]);
            checkOutput("fall4", fall4, mFall[0]);
            checkOutput("busy4", busy4, mBusy[0]);
            checkOutput("pend4", pend4, mPend[0]);
            checkOutput("conf4", conf4, mConf[0]);
            checkOutput("sig1",  sig1,  mSig[1]);
            checkOutput("rise1", rise1, mRise[1]);
            checkOutput("fall1", fall1, mFall[1]);
            checkOutput("busy1", busy1, mBusy[1]);
            checkOutput("pend1", pend1, mPend[1]);
            checkOutput("conf1", conf1, mConf[1]);
        end
    end

    initial begin
        logic r, s, c;

        #2;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkEn = 1'b1;
        checkOutput("reset sig4", sig4, 1'b0);
        checkOutput("reset busy4", busy4, 1'b0);
        checkOutput("reset pend4", pend4, 1'b0);
        checkOutput("reset sig1 INIT", sig1, 1'b1);
        checkOutput("model reset sig1", mSig[1], 1'b1);

        // Set from idle: one-edge latency, busy for exactly four cycles.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("set sig4", sig4, 1'b1);
        checkOutput("set rise4", rise4, 1'b1);
        checkOutput("set busy4", busy4, 1'b1);
        checkOutput("model set sig4", mSig[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("hold busy4", busy4, 1'b1);
            checkOutput("hold rise4", rise4, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("end busy4", busy4, 1'b0);
        checkOutput("model end busy4", mBusy[0], 1'b0);

        // Redundant set while already high is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("noeff sig4", sig4, 1'b1);
        checkOutput("noeff rise4", rise4, 1'b0);
        checkOutput("noeff busy4", busy4, 1'b0);

        // Clear, then set and clear inside the window: buffer cancels.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clr sig4", sig4, 1'b0);
        checkOutput("clr fall4", fall4, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("buffered pend4", pend4, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("cancel pend4", pend4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cancel busy4", busy4, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("cancel idle busy4", busy4, 1'b0);
        checkOutput("cancel idle sig4", sig4, 1'b0);

        // Set then clear one edge later: the clear lands exactly HOLD later.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s2 sig4", sig4, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("s2 pend4", pend4, 1'b1);
        checkOutput("model s2 pend4", mPend[0], 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s2 still high", sig4, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s2 sig4 low", sig4, 1'b0);
        checkOutput("s2 fall4", fall4, 1'b1);
        checkOutput("s2 busy4", busy4, 1'b1);
        checkOutput("s2 pend4 clear", pend4, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("s2 idle busy4", busy4, 1'b0);

        // Simultaneous set and clear.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("conflict4", conf4, 1'b1);
        checkOutput("conflict sig4", sig4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("conflict4 pulse", conf4, 1'b0);

        // Reset in the middle of a hold with a request buffered.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre-reset pend4", pend4, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("midreset sig4", sig4, 1'b0);
        checkOutput("midreset busy4", busy4, 1'b0);
        checkOutput("midreset pend4", pend4, 1'b0);
        checkOutput("midreset sig1", sig1, 1'b1);

        // HOLD=1 instance toggles on every edge.
        for (int k = 0; k < 8; k++) begin
            s = k[0];
            applyStimulus(1'b0, s, ~s);
            checkOutput("alt sig1", sig1, s);
            checkOutput("alt rise1", rise1, s);
            checkOutput("alt fall1", fall1, ~s);
            checkOutput("alt busy1", busy1, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("alt idle busy1", busy1, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
            s = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            c = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            applyStimulus(r, s, c);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/output_conditioner.md
Name: output_conditioner

Overview:
- Output-side counterpart of the input conditioning path: converts 1-clk edge-request pulses into a clean registered level `sig_out`.
- Each `sig_out` level is guaranteed stable for at least HOLD cycles, so a debouncing receiver with delay ≤ HOLD always accepts every transition.
- Requests that arrive during a hold window are buffered (depth 1) and applied at the earliest legal edge.
- Sits between control logic and pins or inter-block lines that feed a debouncing receiver.

Parameters:
- HOLD, 4, minimum stable width of `sig_out` in clk cycles; legal range 1..2^W.
- W, 3, hold counter width in bits.
- INIT, 1'b0, `sig_out` level after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- set_req  input  1  1-clk request to drive `sig_out` high.
- clr_req  input  1  1-clk request to drive `sig_out` low.
- sig_out  output  1  conditioned registered level.
- rising  output  1  1-clk pulse in the first cycle `sig_out` is high after a 0→1 change.
- falling  output  1  1-clk pulse in the first cycle `sig_out` is low after a 1→0 change.
- busy  output  1  high while a hold window is active.
- pend  output  1  high while a buffered request waits.
- conflict  output  1  1-clk pulse when `set_req` and `clr_req` are sampled high on the same edge.

Behaviour:
- Reset, sampled at posedge: `sig_out`=INIT; `rising`=`falling`=`busy`=`pend`=`conflict`=0; cnt=0; state=IDLE; pending buffer cleared. Reset overrides all requests and any in-progress hold.
- Request decode, per edge:
  - set&clr both high → no request; `conflict`=1 next cycle; pending buffer unchanged.
  - Otherwise `req_lvl` = 1 for set, 0 for clr.
  - A request is *effective* only if `req_lvl` ≠ `sig_out`.
- Two-state FSM:
  - IDLE, effective request at edge e → `sig_out` flips at edge e (visible in cycle after e); `rising`/`falling` high that cycle only; state=HOLD; cnt=HOLD-1; `busy`=1. Latency is 1 edge.
  - IDLE, non-effective request → ignored; no pulse.
  - HOLD, cnt≠0 → cnt decrements. A new request is stored as pending, last one wins, replacing any older one. `pend`=1 from the next cycle.
  - HOLD, cnt≠0, stored request equals current `sig_out` (set after clr within one window) → buffer cleared, `pend`=0.
  - HOLD, cnt==0 → candidate is the new request at this edge, else the pending one; a new request has priority.
    - Candidate effective → flip `sig_out`, pulse, cnt=HOLD-1, stay HOLD, clear pending.
    - Otherwise → state=IDLE, `busy`=0, clear pending.
- `busy` is high for exactly HOLD consecutive cycles per transition. Earliest next flip is edge e+HOLD, so the minimum `sig_out` width equals HOLD.
- HOLD=1: back-to-back flips on consecutive edges are legal.
- `rising` and `falling` are never high together. Each is high only in the cycle directly after a flip.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then `set_req` pulse at edge 2 (HOLD=4) → `sig_out`=1 and `rising`=1 in cycle 3; `busy`=1 for cycles 3–6; `busy`=0 in cycle 7.
- `sig_out`=1 in IDLE, `set_req` pulse → no change; `rising`=0, `busy`=0.
- `set_req` at edge 0, `clr_req` at edge 1 → `pend`=1 from cycle 2; `sig_out` falls at edge 4 (width exactly 4); `falling`=1 in cycle 5; `busy` high again for cycles 5–8.
- `set_req` at edge 0, then `clr_req` at edge 1 and `set_req` at edge 2 → `pend`=0 from cycle 3; `sig_out` stays 1; `busy`=0 from cycle 5.
- `set_req`&`clr_req` together at edge 3 → `conflict`=1 in cycle 4 only; `sig_out` unchanged.
- Reset asserted mid-hold (cnt=2, `pend`=1) → next cycle `sig_out`=INIT, `busy`=`pend`=0; HOLD=1 build: alternating set/clr every edge → `sig_out` toggles every cycle with matching pulses.
